// File: rtl/piso_serializer_if.sv
// Handshake and serial-stream bundle for the parallel-in/serial-out stage.
// The master side sources words and shift_en; the slave side is the serializer.
interface piso_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             shift_en;
    logic             ser_out;
    logic             ser_valid;
    logic             word_done;
    logic             busy;

    modport master (
        output in_data, in_valid, shift_en,
        input  in_ready, ser_out, ser_valid, word_done, busy
    );

    modport slave (
        input  in_data, in_valid, shift_en,
        output in_ready, ser_out, ser_valid, word_done, busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage with a one-word holding register, stall input,
// selectable bit order and a fixed idle line level between words.
module piso_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter logic        IDLE_BIT  = 1'b0
) (
    input logic              clock,
    input logic              rst,
    piso_serializer_if.slave sif
);
    localparam int unsigned     CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] shreg, shreg_d;
    logic [WIDTH-1:0] hold_reg, hold_d;
    logic             hold_full, hold_full_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic             word_done_q, word_done_d;

    logic             accept;
    logic             last_bit;
    logic             cur_bit;
    logic [WIDTH-1:0] shifted;

    // The bit on the line is always the shifter's leading end; consuming a bit
    // moves the next one into that position.
    assign cur_bit = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
    assign shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

    assign accept   = sif.in_valid && !hold_full;
    assign last_bit = (state == SHIFT) && sif.shift_en && (cnt == LAST);

    always_ff @(posedge clock) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            hold_reg    <= '0;
            hold_full   <= 1'b0;
            cnt         <= '0;
            word_done_q <= 1'b0;
        end else begin
            state       <= state_d;
            shreg       <= shreg_d;
            hold_reg    <= hold_d;
            hold_full   <= hold_full_d;
            cnt         <= cnt_d;
            word_done_q <= word_done_d;
        end
    end

    always_comb begin
        state_d     = state;
        shreg_d     = shreg;
        hold_d      = hold_reg;
        hold_full_d = hold_full;
        cnt_d       = cnt;
        word_done_d = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    shreg_d = sif.in_data;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (sif.shift_en) begin
                    if (cnt == LAST) begin
                        word_done_d = 1'b1;
                        cnt_d       = '0;
                        if (hold_full) begin
                            shreg_d     = hold_reg;
                            hold_full_d = 1'b0;
                        end else if (accept) begin
                            shreg_d = sif.in_data;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        shreg_d = shifted;
                        cnt_d   = cnt + 1'b1;
                    end
                end
                // A word arriving on the last-bit edge bypasses the holding register.
                if (accept && !last_bit) begin
                    hold_d      = sif.in_data;
                    hold_full_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sif.in_ready  = !hold_full;
    assign sif.ser_valid = (state == SHIFT);
    assign sif.ser_out   = (state == SHIFT) ? cur_bit : IDLE_BIT;
    assign sif.word_done = word_done_q;
    assign sif.busy      = (state == SHIFT) || hold_full;
endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: MSB-first and LSB-first instances,
// back-to-back streaming, stall, mid-word reset and an idle-line pattern check.
module tb_piso_serializer;
    logic clock = 1'b0;
    logic rst;

    always #5 clock = ~clock;

    piso_serializer_if #(.WIDTH(8)) m_if ();
    piso_serializer_if #(.WIDTH(8)) l_if ();

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
        .clock (clock),
        .rst   (rst),
        .sif   (m_if)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
        .clock (clock),
        .rst   (rst),
        .sif   (l_if)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Scoreboard entries: {last_bit_of_word, expected_bit}
    logic [1:0] q_m[$];
    logic [1:0] q_l[$];
    logic [1:0] em, el;
    bit         mon_en = 1'b0;
    logic       exp_done_m = 1'b0;
    logic       exp_done_l = 1'b0;
    int         vcnt, ccnt, first_v, last_v;
    int         done_t[$];
    bit         det_en = 1'b0;
    logic [3:0] det_win;
    int         det_hits, det_idle;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int exp_hits(input logic [7:0] w);
        logic [15:0] s;
        int n;
        n = 0;
        s = {4'b0000, w, 4'b0000};
        for (int i = 15; i >= 3; i--)
            if (s[i -: 4] == 4'b1101) n++;
        return n;
    endfunction

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (mon_en) begin
            if (!m_if.ser_valid) check("m_idle_out", m_if.ser_out, 0);
            else begin
                vcnt++;
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
            end
            check("m_word_done", m_if.word_done, exp_done_m);
            if (m_if.word_done) done_t.push_back(cyc);
            exp_done_m = 1'b0;
            if (m_if.ser_valid && m_if.shift_en) begin
                ccnt++;
                if (q_m.size() == 0) check("m_underflow", 1, 0);
                else begin
                    em = q_m.pop_front();
                    check("m_bit", m_if.ser_out, em[0]);
                    exp_done_m = em[1] && !rst;
                end
            end
            if (det_en) begin
                det_win = {det_win[2:0], m_if.ser_out};
                if (det_win == 4'b1101) begin
                    if (m_if.ser_valid) det_hits++;
                    else det_idle++;
                end
            end

            if (!l_if.ser_valid) check("l_idle_out", l_if.ser_out, 0);
            check("l_word_done", l_if.word_done, exp_done_l);
            exp_done_l = 1'b0;
            if (l_if.ser_valid && l_if.shift_en) begin
                if (q_l.size() == 0) check("l_underflow", 1, 0);
                else begin
                    el = q_l.pop_front();
                    check("l_bit", l_if.ser_out, el[0]);
                    exp_done_l = el[1] && !rst;
                end
            end
        end
    end

    task automatic send(input bit lsb, input logic [7:0] w);
        bit rdy;
        int n;
        n = 0;
        if (lsb) begin l_if.in_data = w; l_if.in_valid = 1'b1; end
        else     begin m_if.in_data = w; m_if.in_valid = 1'b1; end
        do begin
            rdy = lsb ? l_if.in_ready : m_if.in_ready;
            tick();
            n++;
        end while (!rdy && n < 50);
        if (!rdy) check("accept_timeout", 0, 1);
        else begin
            for (int i = 0; i < 8; i++) begin
                int b;
                b = lsb ? i : 7 - i;
                if (lsb) q_l.push_back({i == 7, w[b]});
                else     q_m.push_back({i == 7, w[b]});
            end
        end
        if (lsb) l_if.in_valid = 1'b0;
        else     m_if.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q_m.size() != 0 || m_if.ser_valid || q_l.size() != 0 || l_if.ser_valid) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check("drain_timeout", 0, 1);
        tick();
    endtask

    task automatic clear_stats();
        vcnt    = 0;
        ccnt    = 0;
        first_v = -1;
        last_v  = -1;
        done_t.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        m_if.in_data = 8'h5A; m_if.in_valid = 1'b1; m_if.shift_en = 1'b1;
        l_if.in_data = 8'h00; l_if.in_valid = 1'b0; l_if.shift_en = 1'b1;
        tick();
        tick();
        check("rst_in_ready", m_if.in_ready, 1);
        check("rst_busy", m_if.busy, 0);
        check("rst_ser_valid", m_if.ser_valid, 0);
        check("rst_ser_out", m_if.ser_out, 0);
        check("rst_word_done", m_if.word_done, 0);
        m_if.in_valid = 1'b0;
        rst = 1'b0;
        mon_en = 1'b1;
        tick();

        // Single word, MSB first
        clear_stats();
        send(1'b0, 8'hA5);
        drain();
        check("a5_valid_cycles", vcnt, 8);
        check("a5_consumed", ccnt, 8);
        check("a5_done_count", done_t.size(), 1);
        if (done_t.size() >= 1) check("a5_done_time", done_t[0], last_v + 1);

        // LSB-first instance
        send(1'b1, 8'h01);
        drain();
        check("lsb_q_empty", q_l.size(), 0);

        // Back-to-back through the holding register
        clear_stats();
        send(1'b0, 8'hF0);
        send(1'b0, 8'h0F);
        check("b2b_in_ready", m_if.in_ready, 0);
        check("b2b_busy", m_if.busy, 1);
        drain();
        check("b2b_valid_cycles", vcnt, 16);
        check("b2b_contiguous", last_v - first_v, 15);
        check("b2b_done_count", done_t.size(), 2);
        if (done_t.size() >= 2) check("b2b_done_gap", done_t[1] - done_t[0], 8);

        // Stall for three cycles after the third bit
        clear_stats();
        send(1'b0, 8'hA5);
        tick(); tick(); tick();
        m_if.shift_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_out", m_if.ser_out, 0);
            check("stall_valid", m_if.ser_valid, 1);
            tick();
        end
        m_if.shift_en = 1'b1;
        drain();
        check("stall_valid_cycles", vcnt, 11);
        check("stall_consumed", ccnt, 8);
        check("stall_done_count", done_t.size(), 1);

        // Reset after bit 4 with a word waiting in the holding register
        clear_stats();
        send(1'b0, 8'h3C);
        send(1'b0, 8'hC3);
        tick(); tick(); tick();
        check("pre_rst_busy", m_if.busy, 1);
        rst = 1'b1;
        m_if.in_data = 8'hFF;
        m_if.in_valid = 1'b1;
        tick();
        q_m.delete();
        check("mrst_ser_valid", m_if.ser_valid, 0);
        check("mrst_ser_out", m_if.ser_out, 0);
        check("mrst_busy", m_if.busy, 0);
        check("mrst_in_ready", m_if.in_ready, 1);
        check("mrst_word_done", m_if.word_done, 0);
        rst = 1'b0;
        m_if.in_valid = 1'b0;
        tick();
        check("post_rst_word_done", m_if.word_done, 0);
        check("post_rst_busy", m_if.busy, 0);
        tick();

        // Pattern detector fed from the line, idle zeros included
        clear_stats();
        det_win  = 4'b0000;
        det_hits = 0;
        det_idle = 0;
        det_en   = 1'b1;
        tick(); tick(); tick(); tick();
        send(1'b0, 8'b0110_1101);
        drain();
        tick(); tick(); tick(); tick();
        det_en = 1'b0;
        check("det_hits", det_hits, exp_hits(8'b0110_1101));
        check("det_idle_hits", det_idle, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
